// File: rtl/gcd_engine.sv
// gcd_engine: iterative subtract-based greatest common divisor engine.
// One compare-and-subtract per clock in RUN; a zero operand skips RUN entirely
// and returns a_in|b_in. Synchronous active-high reset.
//
// Ports:
//   clk     - clock, rising edge
//   rst     - synchronous active-high reset
//   start   - request pulse, sampled only while idle
//   a_in    - operand A (unsigned), sampled with start
//   b_in    - operand B (unsigned), sampled with start
//   busy    - high from the cycle after an accepted start through the done cycle
//   done    - one-cycle completion pulse
//   result  - GCD of the accepted operands; held until the next completion
//   cycles  - RUN cycles of the last operation, saturating
//             (present only when GCD_CYCLE_COUNT_EN is defined)
//
// Optional feature macro: GCD_CYCLE_COUNT_EN (adds the cycles port and counter).

module gcd_engine #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
`ifdef GCD_CYCLE_COUNT_EN
  ,
  output logic [WIDTH-1:0] cycles
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] op_a_nxt;
  logic [WIDTH-1:0] op_b_nxt;
  logic [WIDTH-1:0] result_nxt;
  logic             busy_nxt;
  logic             done_nxt;
  logic             accept;

  assign accept = (state == S_IDLE) && start;

  // Next-state, datapath and registered-output next values.
  always_comb begin
    state_nxt  = state;
    op_a_nxt   = op_a;
    op_b_nxt   = op_b;
    result_nxt = result;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        busy_nxt = 1'b0;
        if (start) begin
          busy_nxt = 1'b1;
          if ((a_in != '0) && (b_in != '0)) begin
            op_a_nxt  = a_in;
            op_b_nxt  = b_in;
            state_nxt = S_RUN;
          end else begin
            // gcd(0,x) = x and gcd(0,0) = 0, both covered by the OR.
            result_nxt = a_in | b_in;
            done_nxt   = 1'b1;
            state_nxt  = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (op_a == op_b) begin
          result_nxt = op_a;
          done_nxt   = 1'b1;
          state_nxt  = S_DONE;
        end else if (op_a < op_b) begin
          op_b_nxt = op_b - op_a;
        end else begin
          op_a_nxt = op_a - op_b;
        end
      end
      S_DONE: begin
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
      default: begin
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset overrides any transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      op_a   <= op_a_nxt;
      op_b   <= op_b_nxt;
      result <= result_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
    end
  end

`ifdef GCD_CYCLE_COUNT_EN
  logic [WIDTH-1:0] cycles_nxt;

  // Cleared on accept, counts each RUN cycle, saturates at all-ones.
  always_comb begin
    cycles_nxt = cycles;
    if (accept) begin
      cycles_nxt = '0;
    end else if ((state == S_RUN) && (cycles != {WIDTH{1'b1}})) begin
      cycles_nxt = cycles + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycles <= '0;
    end else begin
      cycles <= cycles_nxt;
    end
  end
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_gcd_engine.sv
// tb_gcd_engine: scoreboard bench for gcd_engine at WIDTH=8.
// Expected results come from a behavioural GCD model pushed at start time and
// popped when done pulses. Works with or without GCD_CYCLE_COUNT_EN.

module tb_gcd_engine;

  localparam int unsigned W = 8;
  localparam int unsigned MAXC = (1 << W) - 1;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
`ifdef GCD_CYCLE_COUNT_EN
  logic [W-1:0] cycles;
`endif

  gcd_engine #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a_in   (a_in),
    .b_in   (b_in),
    .busy   (busy),
    .done   (done),
    .result (result)
`ifdef GCD_CYCLE_COUNT_EN
    ,
    .cycles (cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_bad    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Behavioural GCD: g = result, n = RUN cycles (subtractions + 1, 0 for zero operand).
  function automatic void gcd_model(input int unsigned a, input int unsigned b,
                                    output int unsigned g, output int unsigned n);
    n = 0;
    if (a == 0 || b == 0) begin
      g = a | b;
    end else begin
      while (1) begin
        n++;
        if (a == b) break;
        if (a < b) b = b - a;
        else       a = a - b;
      end
      g = a;
    end
  endfunction

  // Pops one expectation per done pulse.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("spurious_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("result", 32'(result), 32'(e.res));
`ifdef GCD_CYCLE_COUNT_EN
        check_eq("cycles", 32'(cycles), 32'(e.cyc));
`endif
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at the first idle negedge.
  // poke>0 re-pulses start with 10,4 at that RUN cycle (must be ignored).
  task automatic run_op(input int unsigned a, input int unsigned b,
                        input int poke, input bit rel_rst);
    int unsigned g, n;
    int i, busy_n, done_at;
    exp_t e;
    gcd_model(a, b, g, n);
    e.res = W'(g);
    e.cyc = (n > MAXC) ? W'(MAXC) : W'(n);
    sb.push_back(e);
    if (rel_rst) rst = 1'b0;
    a_in  = W'(a);
    b_in  = W'(b);
    start = 1'b1;
    i = 0; busy_n = 0; done_at = 0;
    do begin
      @(negedge clk);
      i++;
      if (busy) busy_n++;
      if (done) done_at = i;
      if (i == 1) begin
        start = 1'b0;
        a_in  = W'($urandom);
        b_in  = W'($urandom);
      end
      if (poke > 0 && i == poke) begin
        a_in = 8'd10; b_in = 8'd4; start = 1'b1;
      end
      if (poke > 0 && i == poke + 1) start = 1'b0;
    end while (busy && i < 600);
    check_eq("timeout_busy", 32'(busy), 32'd0);
    check_eq("busy_len", 32'(busy_n), 32'(n + 1));
    check_eq("done_lat", 32'(done_at), 32'(n + 1));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_result", 32'(result), 32'd0);
`ifdef GCD_CYCLE_COUNT_EN
    check_eq("rst_cycles", 32'(cycles), 32'd0);
`endif

    // Start presented on the first edge with reset low.
    run_op(143, 78, 0, 1'b1);
    // Mid-RUN start with 10,4 is ignored, then 10,4 is run from idle.
    run_op(143, 78, 3, 1'b0);
    run_op(10, 4, 0, 1'b0);
    run_op(0, 0, 0, 1'b0);
    run_op(0, 25, 0, 1'b0);
    run_op(25, 0, 0, 1'b0);
    run_op(40, 40, 0, 1'b0);

    // Reset in the 3rd RUN cycle aborts without a done pulse.
    a_in = 8'd143; b_in = 8'd78; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_result", 32'(result), 32'd0);
`ifdef GCD_CYCLE_COUNT_EN
    check_eq("abort_cycles", 32'(cycles), 32'd0);
`endif
    run_op(21, 14, 0, 1'b1);

    // Saturation boundary: 255 RUN cycles.
    run_op(255, 1, 0, 1'b0);
    run_op(1, 255, 0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      run_op($urandom_range(0, 255), $urandom_range(1, 255), 0, 1'b0);
    end

    repeat (4) @(negedge clk);
    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
